// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero normalize / denormalize pair.
// Both ends derive the count width from the same function, so a count
// produced by the detector always fits the denormalizer's count port.
//
// Contents:
//   cnt_width(width) : bits needed to encode a count of 0..width
//   LZD_WIDTH_DEFAULT : default datapath width
//
// The per-stage record {valid, data, cnt, ovf, err} depends on the datapath
// width, so each module declares its own packed struct with that field order.
package lzd_pkg;

  localparam int LZD_WIDTH_DEFAULT = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzd_denorm_stage.sv
// One pipeline stage of the logarithmic right shifter.
// When enabled, it registers the incoming record and shifts the data right
// by 2**shift if count bit `shift` is set. When disabled, it holds.
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (clears all fields)
//   en_i         : global pipeline enable (low while the output is stalled)
//   valid_i/data_i/cnt_i/ovf_i/err_i : record from the previous stage
//   valid_o/data_o/cnt_o/ovf_o/err_o : registered record for the next stage
module lzd_denorm_stage #(
  parameter int width = 8,
  parameter int cw    = 4,
  parameter int shift = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [width-1:0] data_i,
  input  logic [cw-1:0]    cnt_i,
  input  logic             ovf_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [width-1:0] data_o,
  output logic [cw-1:0]    cnt_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int shamt = 1 << shift;

  logic             valid_d, valid_q;
  logic [width-1:0] data_d,  data_q;
  logic [cw-1:0]    cnt_d,   cnt_q;
  logic             ovf_d,   ovf_q;
  logic             err_d,   err_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (en_i) begin
      valid_d = valid_i;
      // Logical shift: vacated MSBs fill with zero.
      data_d  = cnt_i[shift] ? (data_i >> shamt) : data_i;
      cnt_d   = cnt_i;
      ovf_d   = ovf_i;
      err_d   = err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

endmodule

// File: rtl/lzd_denormalize.sv
// Denormalizer: reconstructs Res = D >> Cnt from a normalized word and its
// leading-zero count, and regenerates the one-hot leading-'1' vector of Res.
// Built as cw registered shift stages (stage s shifts by 2**s), so the
// latency is exactly cw cycles.
//
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i, in_ready_o   : input handshake
//   D_i, Cnt_i               : normalized operand and its leading-zero count
//   out_valid_o, out_ready_i : output handshake
//   Res_o                    : denormalized operand
//   Z_o                      : one-hot leading '1' of Res_o (zero if Res_o==0)
//   Ovf_o                    : the beat carried Cnt_i > width
//   Err_o                    : the beat had Cnt_i < width with D_i MSB clear
//
// Handshake: a beat enters when in_valid_i & in_ready_o and leaves when
// out_valid_o & out_ready_i. stall = out_valid_o & ~out_ready_i freezes every
// stage. in_ready_o = ~stall, so a beat is taken in the same cycle a stalled
// output drains. Bubbles move with the pipeline and are not squeezed out.
module lzd_denormalize
  import lzd_pkg::*;
#(
  parameter  int width = LZD_WIDTH_DEFAULT,
  localparam int cw    = cnt_width(width)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] D_i,
  input  logic [cw-1:0]    Cnt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] Res_o,
  output logic [width-1:0] Z_o,
  output logic             Ovf_o,
  output logic             Err_o
);

  typedef struct packed {
    logic             valid;
    logic [width-1:0] data;
    logic [cw-1:0]    cnt;
    logic             ovf;
    logic             err;
  } stage_t;

  stage_t head;          // conditioned input record feeding stage 0
  stage_t pipe [cw];     // registered stage outputs
  logic   stall;
  logic   en;

  // Out-of-range counts force the data to zero up front, so the remaining
  // shift stages need no special case. Err is only reported, never acted on.
  always_comb begin
    head.valid = in_valid_i;
    head.cnt   = Cnt_i;
    head.ovf   = (Cnt_i > cw'(width));
    head.err   = (Cnt_i < cw'(width)) && !D_i[width-1];
    head.data  = head.ovf ? '0 : D_i;
  end

  for (genvar s = 0; s < cw; s++) begin : g_stage
    stage_t src;
    if (s == 0) begin : g_first
      assign src = head;
    end else begin : g_rest
      assign src = pipe[s-1];
    end

    lzd_denorm_stage #(
      .width (width),
      .cw    (cw),
      .shift (s)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en),
      .valid_i (src.valid),
      .data_i  (src.data),
      .cnt_i   (src.cnt),
      .ovf_i   (src.ovf),
      .err_i   (src.err),
      .valid_o (pipe[s].valid),
      .data_o  (pipe[s].data),
      .cnt_o   (pipe[s].cnt),
      .ovf_o   (pipe[s].ovf),
      .err_o   (pipe[s].err)
    );
  end

  assign stall      = pipe[cw-1].valid && !out_ready_i;
  assign en         = !stall;
  assign in_ready_o = !stall;

  assign out_valid_o = pipe[cw-1].valid;
  assign Res_o       = pipe[cw-1].data;
  assign Ovf_o       = pipe[cw-1].valid && pipe[cw-1].ovf;
  assign Err_o       = pipe[cw-1].valid && pipe[cw-1].err;

  // Leading-one detector on Res_o: scanning upward, the highest set bit wins.
  // Derived from Res_o itself so it also holds for Err beats, whose MSB was 0.
  always_comb begin
    Z_o = '0;
    for (int i = 0; i < width; i++) begin
      if (Res_o[i]) begin
        Z_o    = '0;
        Z_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lzd_denormalize.sv
module tb_lzd_denormalize;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int RW = 2 * W + 2;  // {res, z, ovf, err}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  d;
  logic [CW-1:0] cnt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;
  logic [W-1:0]  z;
  logic          ovf;
  logic          err;

  always #5 clk = ~clk;

  lzd_denormalize #(.width(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .D_i         (d),
    .Cnt_i       (cnt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .Res_o       (res),
    .Z_o         (z),
    .Ovf_o       (ovf),
    .Err_o       (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  logic [W-1:0]  obs_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Arithmetic view: divide by 2**cnt, then find the largest power of two
  // not exceeding the result.
  function automatic logic [RW-1:0] model(input logic [W-1:0] dd, input int cc);
    int r;
    int zz;
    bit o;
    bit e;
    o = (cc > W);
    e = (cc < W) && (int'(dd) < (2 ** (W - 1)));
    r = o ? 0 : int'(dd) / (2 ** cc);
    zz = 0;
    for (int p = 0; p < W; p++) if (r >= (2 ** p)) zz = 2 ** p;
    return {W'(r), W'(zz), o, e};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic          hold_v = 1'b0;
  logic [RW-1:0] hold;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (hold_v) chk("stall_hold", {out_valid, res, z, ovf, err}, {1'b1, hold});
      if (!out_valid) chk("flags_idle", {ovf, err}, 2'b00);
      if (out_valid && out_ready) begin
        obs_q.push_back(res);
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else chk("scoreboard", {res, z, ovf, err}, exp_q.pop_front());
      end
      hold_v = out_valid && !out_ready;
      hold   = {res, z, ovf, err};
      if (in_valid && in_ready) exp_q.push_back(model(d, int'(cnt)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] dd, input logic [CW-1:0] cc);
    bit acc;
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    d        = dd;
    cnt      = cc;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) fail_now("wait_out_timeout");
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;
    logic [W-1:0]  res;
    logic [W-1:0]  z;
    logic          ovf;
    logic          err;
  } vec_t;

  vec_t vecs[10];
  bit   rand_done;

  initial begin
    int lat;
    int stale;
    int guard;
    logic [W-1:0] e8;

    rst = 1'b1; in_valid = 1'b1; d = 8'hFF; cnt = 4'd0; out_ready = 1'b1;
    tick(2);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_res_z", {res, z}, 16'h0000);
    chk("reset_flags", {ovf, err}, 2'b00);
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{8'hA0, 4'd2,  8'h28, 8'h20, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 4'd8,  8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 4'd9,  8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h40, 4'd1,  8'h20, 8'h20, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 4'd0,  8'h80, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 4'd7,  8'h01, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 4'd3,  8'h18, 8'h10, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 4'd15, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 4'd3,  8'h00, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{8'h81, 4'd8,  8'h00, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].d, vecs[i].cnt);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_out", i), {res, z, ovf, err},
          {vecs[i].res, vecs[i].z, vecs[i].ovf, vecs[i].err});
      @(posedge clk); #1;
    end
    tick(2);

    // ---------------- streaming with a 3-cycle stall ----------------
    obs_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'h80, CW'(i));
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 5 && c <= 7);
          @(negedge clk);
          chk($sformatf("stream_in_ready_c%0d", c), in_ready, !(c >= 5 && c <= 7));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (obs_q.size() < 6 && guard < 20) begin tick(1); guard++; end
    chk("stream_count", obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      e8 = 8'h80 >> i;
      chk($sformatf("stream_order%0d", i), obs_q[i], e8);
    end
    tick(2);

    // ---------------- reset with beats in flight ----------------
    obs_q.delete();
    send(8'hFF, 4'd1);
    send(8'hFF, 4'd2);
    send(8'hFF, 4'd3);
    rst = 1'b1; in_valid = 1'b1; d = 8'h80; cnt = 4'd0;
    tick(1);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", out_valid, 1'b0);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", stale, 0);
    chk("no_stale_obs", obs_q.size(), 0);
    @(posedge clk); #1;
    send(8'h80, 4'd3);
    wait_out(lat);
    chk("post_reset_latency", lat, 4);
    chk("post_reset_res", {res, z, ovf, err}, {8'h10, 8'h10, 1'b0, 1'b0});
    @(posedge clk); #1;
    tick(2);

    // ---------------- randomized stream ----------------
    rand_done = 1'b0;
    fork
      begin
        logic [W-1:0]  rd;
        logic [CW-1:0] rc;
        for (int n = 0; n < 10000; n++) begin
          rd = W'($urandom);
          if ($urandom_range(0, 3) != 0) rd[W-1] = 1'b1;
          rc = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(9, 15)) : CW'($urandom_range(0, 8));
          send(rd, rc);
          if ($urandom_range(0, 4) == 0) tick($urandom_range(1, 3));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin tick(1); guard++; end
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
